// File: rtl/axis_guard_pkg.sv
// Shared types and defaults for the AXI-Stream packet-length guard.
package axis_guard_pkg;

    // Guard FSM: forward words, or swallow the tail of an oversize packet.
    typedef enum logic {PASS, DISCARD} guard_state_t;

    localparam int unsigned MAX_WORDS_DEFAULT  = 256;
    localparam int unsigned STAT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid stage with a registered input ready.
// The payload is opaque; callers pack whatever sideband they need into it.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push      = in_valid & ready_q;
    assign pop       = (count_q != 2'd0) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, pointers and the registered ready (low only while both slots are full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/axis_pkt_len_guard.sv
// AXI-Stream packet-length guard: truncates packets longer than MAX_WORDS with a
// forced tlast, drops the remainder, and keeps saturating packet/truncation counts.
// The AXIS bundles are carried as flattened axis_in_* / axis_out_* signals.
module axis_pkt_len_guard
    import axis_guard_pkg::*;
#(
    parameter int unsigned MAX_WORDS  = MAX_WORDS_DEFAULT,
    parameter int unsigned STAT_WIDTH = STAT_WIDTH_DEFAULT,
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    aresetn,

    input  logic                    axis_in_tvalid,
    output logic                    axis_in_tready,
    input  logic [DATA_BYTES*8-1:0] axis_in_tdata,
    input  logic [DATA_BYTES-1:0]   axis_in_tkeep,
    input  logic                    axis_in_tlast,

    output logic                    axis_out_tvalid,
    input  logic                    axis_out_tready,
    output logic [DATA_BYTES*8-1:0] axis_out_tdata,
    output logic [DATA_BYTES-1:0]   axis_out_tkeep,
    output logic [DATA_BYTES-1:0]   axis_out_tstrb,
    output logic                    axis_out_tlast,
    output logic [ID_WIDTH-1:0]     axis_out_tid,
    output logic [DEST_WIDTH-1:0]   axis_out_tdest,
    output logic [USER_WIDTH-1:0]   axis_out_tuser,

    input  logic                    stats_clear,
    output logic                    pkt_truncated,
    output logic [STAT_WIDTH-1:0]   pkt_count,
    output logic [STAT_WIDTH-1:0]   trunc_count
);

    localparam int unsigned DATA_W  = DATA_BYTES * 8;
    localparam int unsigned PAY_W   = DATA_W + DATA_BYTES + 1;
    localparam int unsigned CNT_W   = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(MAX_WORDS - 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    guard_state_t          state_q;
    guard_state_t          state_d;
    logic [CNT_W-1:0]      word_cnt_q;
    logic [CNT_W-1:0]      word_cnt_d;
    logic [STAT_WIDTH-1:0] pkt_count_q;
    logic [STAT_WIDTH-1:0] pkt_count_d;
    logic [STAT_WIDTH-1:0] trunc_count_q;
    logic [STAT_WIDTH-1:0] trunc_count_d;
    logic                  pkt_truncated_q;

    logic                  in_hs;
    logic                  at_limit;
    logic                  fwd;
    logic                  fwd_last;
    logic                  truncate;
    logic                  skid_in_valid;
    logic                  skid_ready;
    logic [PAY_W-1:0]      skid_in_data;
    logic [PAY_W-1:0]      skid_out_data;

    // In DISCARD the tail is swallowed without waiting on the output side.
    assign axis_in_tready = (state_q == DISCARD) | skid_ready;
    assign in_hs          = axis_in_tvalid & axis_in_tready;
    assign at_limit       = (word_cnt_q == LAST_IDX);
    assign fwd            = in_hs & (state_q == PASS);
    assign fwd_last       = axis_in_tlast | at_limit;
    assign truncate       = fwd & at_limit & ~axis_in_tlast;

    assign skid_in_valid  = axis_in_tvalid & (state_q == PASS);
    assign skid_in_data   = {axis_in_tdata, axis_in_tkeep, fwd_last};

    axis_skid_buffer #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (aresetn),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_ready),
        .in_data   (skid_in_data),
        .out_valid (axis_out_tvalid),
        .out_ready (axis_out_tready),
        .out_data  (skid_out_data)
    );

    assign axis_out_tdata = skid_out_data[PAY_W-1 -: DATA_W];
    assign axis_out_tkeep = skid_out_data[DATA_BYTES:1];
    assign axis_out_tlast = skid_out_data[0];
    assign axis_out_tstrb = '1;
    assign axis_out_tid   = '0;
    assign axis_out_tdest = '0;
    assign axis_out_tuser = '0;

    assign pkt_truncated  = pkt_truncated_q;
    assign pkt_count      = pkt_count_q;
    assign trunc_count    = trunc_count_q;

    // Next state and word position within the current packet.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        unique case (state_q)
            PASS: begin
                if (in_hs) begin
                    if (axis_in_tlast) begin
                        word_cnt_d = '0;
                    end else if (at_limit) begin
                        word_cnt_d = '0;
                        state_d    = DISCARD;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (in_hs && axis_in_tlast) begin
                    state_d = PASS;
                end
            end
        endcase
    end

    // Saturating statistics; a clear overrides a same-cycle increment.
    always_comb begin
        pkt_count_d   = pkt_count_q;
        trunc_count_d = trunc_count_q;
        if (stats_clear) begin
            pkt_count_d   = '0;
            trunc_count_d = '0;
        end else begin
            if (fwd && fwd_last && (pkt_count_q != STAT_MAX)) begin
                pkt_count_d = pkt_count_q + 1'b1;
            end
            if (truncate && (trunc_count_q != STAT_MAX)) begin
                trunc_count_d = trunc_count_q + 1'b1;
            end
        end
    end

    // State, counters and the truncation pulse register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= PASS;
            word_cnt_q      <= '0;
            pkt_count_q     <= '0;
            trunc_count_q   <= '0;
            pkt_truncated_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            pkt_count_q     <= pkt_count_d;
            trunc_count_q   <= trunc_count_d;
            pkt_truncated_q <= truncate;
        end
    end

endmodule
